// File: rtl/ssdma_pkg.sv
// ssdma_pkg -- shared definitions for the DMA descriptor memory slave.
//
// Contents:
//   dm_state_t      bus-side FSM encoding (S_IDLE, S_BEAT, S_DONE)
//   BURST_LEN_DEF   default beats per cab burst (one descriptor)
//   DESC_* / DC_*   descriptor field positions used by the DMA controller
//   sel_to_be()     expands the 4-bit Wishbone select to 8 byte lanes
package ssdma_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BEAT = 2'd1,
        S_DONE = 2'd2
    } dm_state_t;

    localparam int BURST_LEN_DEF = 4;

    // Next-descriptor pointer lives in the high half, control address in the
    // low half; both are 8-byte aligned so bits [2:0] carry no address.
    localparam int DESC_NEXT_MSB = 31;
    localparam int DESC_NEXT_LSB = 3;
    localparam int DESC_CTLA_MSB = 31;
    localparam int DESC_CTLA_LSB = 3;

    // Descriptor control (dc) flag bits.
    localparam int DC_CTL_WB_BIT = 7;
    localparam int DC_CHAIN_BIT  = 14;
    localparam int DC_IRQ_BIT    = 15;

    // The same 4-bit select qualifies both 32-bit halves of the word.
    function automatic logic [7:0] sel_to_be(input logic [3:0] sel);
        return {sel, sel};
    endfunction

endpackage

// File: rtl/desc_mem_ram.sv
// desc_mem_ram -- 2^AW x 64-bit single-port RAM with 8 byte-lane enables.
//
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset (read register only)
//   en           port access this cycle
//   we           write (1) or read (0) when en
//   be[7:0]      byte-lane enables for writes
//   addr[AW-1:0] word address
//   wdata[63:0]  write data
//   rdata[63:0]  registered read data, updated only by a read access
module desc_mem_ram #(
    parameter int AW = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          we,
    input  logic [7:0]    be,
    input  logic [AW-1:0] addr,
    input  logic [63:0]   wdata,
    output logic [63:0]   rdata
);

    logic [63:0] mem [0:(1<<AW)-1];

    // Storage is deliberately not reset; descriptors survive a bus reset.
    always_ff @(posedge clk) begin
        if (en && we) begin
            for (int i = 0; i < 8; i++) begin
                if (be[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    // Read register holds its value across writes and idle cycles so a bus
    // wait state keeps presenting the same beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (en && !we) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/desc_mem_slave.sv
// desc_mem_slave -- Wishbone descriptor/control memory for DMA port 4.
//
// Serves 4-beat linear cab bursts and single accesses out of a 2^AW x 64-bit
// memory, with registered ack/rty/err. A host port preloads descriptors and
// reads back status; it has priority in S_IDLE and the bus gets rty then.
//
// Optional feature: define DESC_MEM_ERR_EN to enable the address window
// check (err on out-of-window start or on a burst crossing the window end).
// Without it addresses wrap modulo 2^AW and wbs_err_o is tied to 0.
//
// Ports:
//   wb_clk_i, wb_rst_n_i        clock, asynchronous active-low reset
//   wbs_cyc/stb/we/cab/sel/adr  Wishbone request from the DMA controller
//   wbs_dat_i / wbs_dat64_i     write data, low / high 32-bit half
//   wbs_dat_o / wbs_dat64_o     read data, low (ctl addr) / high (payload)
//   wbs_ack_o/rty_o/err_o       registered, mutually exclusive responses
//   hst_req/we/adr/dat_i        host access request
//   hst_gnt_o                   host access performed this cycle
//   hst_dat_o                   host read data, one cycle after hst_gnt_o
//   busy_o                      bus transaction in progress
module desc_mem_slave
    import ssdma_pkg::*;
#(
    parameter int          AW        = 6,
    parameter logic [31:0] BASE      = 32'h0000_0000,
    parameter int          BURST_LEN = BURST_LEN_DEF
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_n_i,
    input  logic          wbs_cyc_i,
    input  logic          wbs_stb_i,
    input  logic          wbs_we_i,
    input  logic          wbs_cab_i,
    input  logic [3:0]    wbs_sel_i,
    input  logic [31:0]   wbs_adr_i,
    input  logic [31:0]   wbs_dat_i,
    input  logic [31:0]   wbs_dat64_i,
    output logic [31:0]   wbs_dat_o,
    output logic [31:0]   wbs_dat64_o,
    output logic          wbs_ack_o,
    output logic          wbs_rty_o,
    output logic          wbs_err_o,
    input  logic          hst_req_i,
    input  logic          hst_we_i,
    input  logic [AW-1:0] hst_adr_i,
    input  logic [63:0]   hst_dat_i,
    output logic          hst_gnt_o,
    output logic [63:0]   hst_dat_o,
    output logic          busy_o
);

    localparam int CW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    dm_state_t     state, state_n;
    logic [AW-1:0] ptr, ptr_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          we_q, we_n;
    logic          cab_q, cab_n;
    logic          ack_p1, ack_n;
    logic          rty_p1, rty_n;
    logic          err_p1, err_n;

    logic          req;
    logic [31:0]   off;
    logic [AW-1:0] widx;
    logic          out_win;
    logic          at_top;
    logic          last_beat;

    logic          ram_en;
    logic          ram_we;
    logic [7:0]    ram_be;
    logic [AW-1:0] ram_addr;
    logic [63:0]   ram_wdata;
    logic [63:0]   ram_rdata;

    assign req  = wbs_cyc_i & wbs_stb_i;
    assign off  = wbs_adr_i - BASE;
    assign widx = off[AW+2:3];

`ifdef DESC_MEM_ERR_EN
    localparam logic [32:0] LIMIT = {1'b0, BASE} + (33'd1 << (AW + 3));
    assign out_win = (wbs_adr_i < BASE) || ({1'b0, wbs_adr_i} >= LIMIT);
    // The last word of the window: advancing past it leaves the window.
    assign at_top  = &ptr;
`else
    assign out_win = 1'b0;
    assign at_top  = 1'b0;
`endif

    assign last_beat = cab_q ? (cnt == CW'(BURST_LEN - 1)) : 1'b1;

    assign hst_gnt_o = hst_req_i & (state == S_IDLE);

    always_comb begin
        state_n   = state;
        ptr_n     = ptr;
        cnt_n     = cnt;
        we_n      = we_q;
        cab_n     = cab_q;
        ack_n     = 1'b0;
        rty_n     = 1'b0;
        err_n     = 1'b0;
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_be    = 8'h00;
        ram_addr  = ptr;
        ram_wdata = {wbs_dat64_i, wbs_dat_i};

        unique case (state)
            S_IDLE: begin
                if (hst_req_i) begin
                    // Host owns the RAM port; a colliding bus request is retried.
                    ram_en    = 1'b1;
                    ram_we    = hst_we_i;
                    ram_be    = 8'hFF;
                    ram_addr  = hst_adr_i;
                    ram_wdata = hst_dat_i;
                    rty_n     = req;
                end else if (req) begin
                    if (out_win) begin
                        err_n   = 1'b1;
                        state_n = S_DONE;
                    end else begin
                        ptr_n   = widx;
                        cnt_n   = '0;
                        we_n    = wbs_we_i;
                        cab_n   = wbs_cab_i;
                        ack_n   = 1'b1;
                        state_n = S_BEAT;
                        // Prefetch beat 0 so its data lines up with the first ack.
                        ram_en   = ~wbs_we_i;
                        ram_addr = widx;
                    end
                end
            end

            S_BEAT: begin
                if (!wbs_cyc_i) begin
                    state_n = S_IDLE;
                end else if (wbs_stb_i && ack_p1) begin
                    // Beat completes at this edge.
                    if (we_q) begin
                        ram_en   = 1'b1;
                        ram_we   = 1'b1;
                        ram_be   = sel_to_be(wbs_sel_i);
                        ram_addr = ptr;
                    end
                    ptr_n = ptr + AW'(1);
                    cnt_n = cnt + CW'(1);
                    if (last_beat) begin
                        state_n = S_DONE;
                    end else if (at_top) begin
                        err_n   = 1'b1;
                        state_n = S_DONE;
                    end else begin
                        ack_n = 1'b1;
                        if (!we_q) begin
                            ram_en   = 1'b1;
                            ram_addr = ptr + AW'(1);
                        end
                    end
                end else begin
                    // Wait state or re-presentation after one: pointer holds.
                    ack_n = wbs_stb_i;
                end
            end

            S_DONE: begin
                if (!wbs_cyc_i) begin
                    state_n = S_IDLE;
                end
            end

            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state  <= S_IDLE;
            ptr    <= '0;
            cnt    <= '0;
            we_q   <= 1'b0;
            cab_q  <= 1'b0;
            ack_p1 <= 1'b0;
            rty_p1 <= 1'b0;
            err_p1 <= 1'b0;
        end else begin
            state  <= state_n;
            ptr    <= ptr_n;
            cnt    <= cnt_n;
            we_q   <= we_n;
            cab_q  <= cab_n;
            ack_p1 <= ack_n;
            rty_p1 <= rty_n;
            err_p1 <= err_n;
        end
    end

    desc_mem_ram #(
        .AW(AW)
    ) u_ram (
        .clk   (wb_clk_i),
        .rst_n (wb_rst_n_i),
        .en    (ram_en),
        .we    (ram_we),
        .be    (ram_be),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    assign wbs_ack_o   = ack_p1;
    assign wbs_rty_o   = rty_p1;
    assign wbs_dat_o   = ram_rdata[31:0];
    assign wbs_dat64_o = ram_rdata[63:32];
    assign hst_dat_o   = ram_rdata;
    assign busy_o      = (state != S_IDLE);

    logic unused_ok;
`ifdef DESC_MEM_ERR_EN
    assign wbs_err_o = err_p1;
    assign unused_ok = ^{off[2:0], off[31:AW+3]};
`else
    assign wbs_err_o = 1'b0;
    assign unused_ok = ^{off[2:0], off[31:AW+3], err_p1};
`endif

endmodule
